// File: rtl/cam_wr_buffer.sv
// Write buffer between camera capture and the DDR user write port.
// It queues address/data pairs in FIFO order, counts dropped words and reports when a finished frame has drained.
module cam_wr_buffer #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 25,
    parameter int DEPTH  = 16
) (
    input  logic                       p_clk,
    input  logic                       rst_n,
    input  logic [DATA_W-1:0]          in_data,
    input  logic [ADDR_W-1:0]          in_address,
    input  logic                       in_valid,
    input  logic                       frame_done,
    input  logic                       clear_ovf,
    output logic [DATA_W-1:0]          mem_wr_data,
    output logic [ADDR_W-1:0]          mem_wr_addr,
    output logic                       mem_wr_valid,
    input  logic                       mem_wr_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic [15:0]                drop_count,
    output logic                       frame_flushed
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int ENTRY_W = ADDR_W + DATA_W;

    typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [ENTRY_W-1:0] r_out;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [LVL_W-1:0]   r_level;
    logic [LVL_W-1:0]   w_level_next;
    logic               r_valid;
    logic               r_overflow;
    logic [15:0]        r_drop_count;
    logic               r_frame_flushed;
    state_t             r_state;
    state_t             w_state_next;

    logic               w_full;
    logic               w_push;
    logic               w_drop;
    logic               w_pop;
    logic               w_flush_done;
    logic [PTR_W-1:0]   w_rd_ptr_inc;

    // Full is judged on the pre-edge level, so a pop in the same cycle never frees room for the push.
    assign w_full       = (r_level == LVL_W'(DEPTH));
    assign w_push       = in_valid && !w_full;
    assign w_drop       = in_valid && w_full;
    assign w_pop        = r_valid && mem_wr_ready;
    assign w_rd_ptr_inc = r_rd_ptr + PTR_W'(1);

    always_comb begin
        w_level_next = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_next = r_level + LVL_W'(1);
            2'b01:   w_level_next = r_level - LVL_W'(1);
            default: w_level_next = r_level;
        endcase
    end

    always_ff @(posedge p_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_address, in_data};
        end
    end

    always_ff @(posedge p_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_valid  <= 1'b0;
            r_out    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= w_rd_ptr_inc;
            r_level <= w_level_next;
            r_valid <= (w_level_next != '0);
            // The output register always holds the head entry; the incoming word bypasses the array when it becomes head.
            if (w_push && ((r_level == '0) || ((r_level == LVL_W'(1)) && w_pop))) begin
                r_out <= {in_address, in_data};
            end else if (w_pop && (r_level > LVL_W'(1))) begin
                r_out <= r_mem[w_rd_ptr_inc];
            end
        end
    end

    always_ff @(posedge p_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (clear_ovf) begin
                r_drop_count <= 16'd1;
            end else if (r_drop_count != 16'hFFFF) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end else if (clear_ovf) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end
    end

    always_ff @(posedge p_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_RUN;
            r_frame_flushed <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_frame_flushed <= w_flush_done;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN:   if (frame_done) w_state_next = ST_FLUSH;
            ST_FLUSH: if (w_flush_done) w_state_next = ST_RUN;
            default:  w_state_next = ST_RUN;
        endcase
    end

    always_comb begin
        w_flush_done = (r_state == ST_FLUSH) && (r_level == '0) && !w_push;
    end

    assign {mem_wr_addr, mem_wr_data} = r_out;
    assign mem_wr_valid  = r_valid;
    assign level         = r_level;
    assign overflow      = r_overflow;
    assign drop_count    = r_drop_count;
    assign frame_flushed = r_frame_flushed;

endmodule

// File: doc/cam_wr_buffer.md
Name: cam_wr_buffer

Overview:
- Buffers 128-bit pixel words and their DDR word addresses from the camera capture stage.
- Presents them to the DDR write port over a valid/ready handshake, absorbing DDR back-pressure.
- Flags dropped words and signals when all words of a finished frame have been handed to memory.
- Sits between camera capture (data_valid/p_data/wr_address/frame_done) and the DDR user write interface, all in the p_clk domain.

Parameters:
- DATA_W, 128, pixel word width (8 pixels x 16 bit).
- ADDR_W, 25, DDR word address width.
- DEPTH, 16, total entry capacity including the output stage; power of 2, at least 2.

Ports:
- p_clk  in  1  pixel clock; all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  DATA_W  pixel word from capture.
- in_address  in  ADDR_W  DDR address of in_data.
- in_valid  in  1  single-cycle push strobe, no ready back to capture.
- frame_done  in  1  one-cycle end-of-frame pulse from capture.
- clear_ovf  in  1  synchronous clear of overflow and drop_count.
- mem_wr_data  out  DATA_W  word to DDR.
- mem_wr_addr  out  ADDR_W  address to DDR.
- mem_wr_valid  out  1  word available.
- mem_wr_ready  in  1  DDR accepts word.
- level  out  clog2(DEPTH)+1  entries held, range 0..DEPTH.
- overflow  out  1  sticky; a word was dropped.
- drop_count  out  16  dropped words, saturating.
- frame_flushed  out  1  one-cycle pulse; frame fully handed off.

Behaviour:
- Async reset: level=0, mem_wr_valid=0, mem_wr_data=0, mem_wr_addr=0, overflow=0, drop_count=0, frame_flushed=0, FSM=RUN, contents discarded. Reset may assert at any time, including mid-drain.
- Push accepted iff in_valid=1 and level<DEPTH at the clock edge.
  - Full is evaluated before a same-cycle pop: at level==DEPTH a push is rejected even if a pop also occurs.
- Pop occurs on a cycle with mem_wr_valid=1 and mem_wr_ready=1.
- level update per edge: +1 on accepted push, -1 on pop, unchanged if both or neither.
- mem_wr_valid is always equal to (level!=0). It is registered, not combinational on in_valid.
- Latency: a push into an empty buffer at edge N gives mem_wr_valid=1 with that word after edge N. Minimum latency is 1 cycle.
- Order is strict FIFO. mem_wr_data and mem_wr_addr stay stable while mem_wr_valid=1 and mem_wr_ready=0.
- mem_wr_data and mem_wr_addr are don't-care while mem_wr_valid=0; hold the last value.
- Rejected push:
  - word discarded;
  - overflow<=1;
  - drop_count<=drop_count+1, saturating at 16'hFFFF.
- clear_ovf: overflow<=0 and drop_count<=0. If a drop occurs in the same cycle, the drop wins: overflow=1, drop_count=1.
- FSM states RUN and FLUSH:
  - RUN -> FLUSH on frame_done=1.
  - FLUSH -> RUN at an edge where level==0 and no push is accepted. That same edge sets frame_flushed<=1 for exactly one cycle.
  - frame_done while in FLUSH is absorbed: still only one frame_flushed pulse.
  - Pushes are accepted normally in both states.
- frame_done with an empty buffer: FLUSH after edge N, frame_flushed high after edge N+1 (2-cycle latency).
- Address contents are not checked or modified; in_address passes through unchanged.

Test Plan:
- Empty buffer, one push data=128'hA5..A5 addr=25'h25800, mem_wr_ready=1.
  -> next cycle: mem_wr_valid=1, mem_wr_addr=25'h25800, level=1.
  -> cycle after: level=0, mem_wr_valid=0.
- mem_wr_ready=0, push 17 words at addr 0,4,...,64.
  -> level=16, 17th word dropped, overflow=1, drop_count=1.
  -> raise ready: exactly 16 writes, addr 0..60 in order; addr 64 never seen.
- At level=5, push and pop in the same cycle -> level stays 5, output advances to the next word.
- At level=16, push and pop in the same cycle -> push rejected, level=15, drop_count increments.
- level=3, frame_done pulse, ready low 10 cycles then high.
  -> frame_flushed=0 until level reaches 0.
  -> one-cycle pulse one edge after the pop that emptied the buffer.
  -> empty buffer with frame_done pulse gives the pulse 2 cycles later.
- Force 70000 drops -> drop_count=16'hFFFF.
  -> clear_ovf with no drop gives 0/0.
  -> clear_ovf with a simultaneous drop gives overflow=1, drop_count=1.
  -> async rst_n low mid-drain: all outputs reset immediately; after release level=0, no stale words emitted.
